// File: rtl/thumb_fetch_pkg.sv
// Shared types and helpers for the Thumb fetch/align unit.
package thumb_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  localparam logic [4:0] T32_PFX0 = 5'b11101;
  localparam logic [4:0] T32_PFX1 = 5'b11110;
  localparam logic [4:0] T32_PFX2 = 5'b11111;

  function automatic logic is_t32(input logic [15:0] hw);
    return (hw[15:11] == T32_PFX0) || (hw[15:11] == T32_PFX1) ||
           (hw[15:11] == T32_PFX2);
  endfunction

endpackage

// File: rtl/thumb_hw_fifo.sv
// Halfword queue with 2-wide push and pop; QDEPTH must be a power of two.
module thumb_hw_fifo #(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PW = $clog2(QDEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [1:0]    push_cnt,
  input  logic [15:0]   push_hw0,
  input  logic [15:0]   push_hw1,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] count,
  output logic [15:0]   head0,
  output logic [15:0]   head1
);

  logic [15:0]   mem_q [QDEPTH];
  logic [15:0]   mem_d [QDEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_nxt, rd_nxt;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    wr_nxt = wr_q + PW'(1);
    rd_nxt = rd_q + PW'(1);
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_cnt != 2'd0) mem_d[wr_q] = push_hw0;
      if (push_cnt == 2'd2) mem_d[wr_nxt] = push_hw1;
      wr_d  = wr_q + PW'(push_cnt);
      rd_d  = rd_q + PW'(pop_cnt);
      cnt_d = cnt_q + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[rd_nxt];

endmodule

// File: rtl/thumb_fetch_align.sv
// Fetches 32-bit words, queues halfwords and presents aligned Thumb instructions.
// Define THUMB_FETCH_PERF_EN to add the stall_cnt performance counter output.
module thumb_fetch_align
  import thumb_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is32,
  output logic        inst_valid,
  input  logic        inst_ready
`ifdef THUMB_FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   pc_q, pc_d;
  logic          skip_lo_q, skip_lo_d;

  logic          fifo_clr;
  logic [1:0]    push_cnt, pop_cnt;
  logic [15:0]   push_hw0, push_hw1;
  logic [CW-1:0] fifo_count, cnt_after;
  logic [15:0]   head0, head1;
  logic          head_is32, xfer, req_ok;

  thumb_hw_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fifo_clr),
    .push_cnt (push_cnt),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_cnt  (pop_cnt),
    .count    (fifo_count),
    .head0    (head0),
    .head1    (head1)
  );

  always_comb begin
    head_is32  = is_t32(head0);
    inst_valid = head_is32 ? (fifo_count > CW'(1)) : (fifo_count != '0);
    xfer       = inst_valid && inst_ready && !flush;
    pop_cnt    = xfer ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
    inst       = '0;
    if (inst_valid) inst = head_is32 ? {head0, head1} : {head0, 16'h0000};
    inst_is32  = (fifo_count != '0) && head_is32;
    // Free-slot rule counts this cycle's pop, which is what keeps the queue from overflowing.
    cnt_after  = fifo_count - CW'(pop_cnt);
    req_ok     = cnt_after <= CW'(QDEPTH - 2);
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    skip_lo_d    = skip_lo_q;
    fifo_clr     = 1'b0;
    push_cnt     = 2'd0;
    push_hw0     = mem_rdata[15:0];
    push_hw1     = mem_rdata[31:16];
    mem_req      = 1'b0;
    if (flush) begin
      fifo_clr     = 1'b1;
      fetch_addr_d = flush_pc & 32'hFFFF_FFFC;
      pc_d         = flush_pc & 32'hFFFF_FFFE;
      skip_lo_d    = flush_pc[1];
      // A response still in flight must be discarded unless it is arriving right now.
      state_d      = ((state_q != IDLE) && !mem_rvalid) ? DROP : IDLE;
    end else begin
      if (xfer) pc_d = pc_q + (head_is32 ? 32'd4 : 32'd2);
      case (state_q)
        IDLE: begin
          if (!rst && req_ok) begin
            mem_req = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_d      = IDLE;
            fetch_addr_d = fetch_addr_q + 32'd4;
            skip_lo_d    = 1'b0;
            if (skip_lo_q) begin
              push_cnt = 2'd1;
              push_hw0 = mem_rdata[31:16];
            end else begin
              push_cnt = 2'd2;
            end
          end
        end
        DROP: begin
          if (mem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pc_q         <= '0;
      skip_lo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      skip_lo_q    <= skip_lo_d;
    end
  end

  assign mem_addr = fetch_addr_q;
  assign inst_pc  = pc_q;

`ifdef THUMB_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (inst_ready && !inst_valid && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
